posit_cast_sched: RTL and testbench

//  Shares one posit_cast_multi conversion unit (int<->posit, 4 opcodes) between NUM_REQ issue ports.
//  - Arbitrates round-robin, with stable-grant semantics.
//  - Tags every issued op with its requester ID and routes each result back to the owner, in order.
//  - Sits between the integer/posit issue stage and the cast unit.

---
 rtl/posit_cast_sched.sv | 193 +++++++++++++++++++
 tb/tb_posit_cast_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_cast_sched.sv
// Purpose : round-robin share of one posit_cast_multi unit between NUM_REQ issue ports, tagged in-order return.
// Latency : 0 cycles issue (request handshake == cast-unit handshake), 0 cycles response routing.
// Backpr. : cu_ready_i=0 freezes the grant (HOLD); tag FIFO full blocks issue; rsp_ready_i of the head owner stalls cu results.
//
// Ports:
//   clk_i/rst_ni/flush_i               clock, async active-low reset, kill in-flight work
//   req_valid_i/req_ready_o            per-port request handshake (ready one-hot or zero)
//   req_operand_i/req_op_i/req_rnd_i   packed per-port payload (port p at slice p)
//   cu_valid_o/cu_ready_i/cu_*_o       granted op towards the cast unit, cu_flush_o mirrors flush_i
//   cu_valid_i/cu_ready_o/cu_result_i/cu_status_i   result from the cast unit
//   rsp_valid_o/rsp_ready_i/rsp_result_o/rsp_status_o  result routed to the owning port
//   busy_o                             op held or in flight
//   err_o                              1-cycle pulse after an untagged result was dropped
module posit_cast_sched #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand_i,
  input  logic [NUM_REQ*2-1:0]     req_op_i,
  input  logic [NUM_REQ*3-1:0]     req_rnd_i,
  output logic                     cu_valid_o,
  input  logic                     cu_ready_i,
  output logic [WIDTH-1:0]         cu_operand_o,
  output logic [1:0]               cu_op_o,
  output logic [2:0]               cu_rnd_o,
  output logic                     cu_flush_o,
  input  logic                     cu_valid_i,
  output logic                     cu_ready_o,
  input  logic [WIDTH-1:0]         cu_result_i,
  input  logic [4:0]               cu_status_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_result_o,
  output logic [4:0]               rsp_status_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {ST_ARB, ST_HOLD} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_hold_id;
  logic [IW-1:0]   r_tags [MAX_OUT];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_err;

  logic            w_arb_any;
  logic [IW-1:0]   w_arb_id;
  logic [IW-1:0]   w_grant;
  logic [IW-1:0]   w_next_rr;
  logic [IW-1:0]   w_head;
  logic            w_issue_ok;
  logic            w_cu_vld;
  logic            w_push;
  logic            w_tagged;
  logic            w_cu_rdy;
  logic            w_pop;
  logic            w_drop;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin scan starting at r_rr_ptr; the first valid port wins.
  always_comb begin
    logic [IW-1:0] v_idx;
    v_idx     = '0;
    w_arb_any = 1'b0;
    w_arb_id  = r_rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = IW'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_arb_any && req_valid_i[v_idx]) begin
        w_arb_any = 1'b1;
        w_arb_id  = v_idx;
      end
    end
  end

  always_comb begin
    w_grant    = (r_state == ST_HOLD) ? r_hold_id : w_arb_id;
    w_next_rr  = (w_grant == IW'(NUM_REQ - 1)) ? '0 : w_grant + IW'(1);
    // Full check uses the registered count, so a same-cycle pop cannot free a slot.
    w_issue_ok = !flush_i && (r_count < CW'(MAX_OUT));
    w_cu_vld   = w_issue_ok && ((r_state == ST_HOLD) || w_arb_any);
    w_push     = w_cu_vld && cu_ready_i;
    w_head     = r_tags[r_rd_ptr];
    w_tagged   = cu_valid_i && (r_count != '0) && !flush_i;
    // With nothing tagged (or while flushing) results are sunk so the cast unit never wedges.
    w_cu_rdy   = ((r_count != '0) && !flush_i) ? rsp_ready_i[w_head] : 1'b1;
    w_pop      = w_tagged && w_cu_rdy;
    w_drop     = cu_valid_i && (r_count == '0) && !flush_i;
  end

  // Outputs are forced to zero while reset is asserted, including the pass-through paths.
  always_comb begin
    req_ready_o  = '0;
    cu_valid_o   = 1'b0;
    cu_operand_o = '0;
    cu_op_o      = '0;
    cu_rnd_o     = '0;
    cu_flush_o   = 1'b0;
    cu_ready_o   = 1'b0;
    rsp_valid_o  = '0;
    rsp_result_o = '0;
    rsp_status_o = '0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
    if (rst_ni) begin
      cu_flush_o = flush_i;
      cu_valid_o = w_cu_vld;
      if (w_cu_vld) begin
        cu_operand_o = req_operand_i[int'(w_grant)*WIDTH +: WIDTH];
        cu_op_o      = req_op_i[int'(w_grant)*2 +: 2];
        cu_rnd_o     = req_rnd_i[int'(w_grant)*3 +: 3];
      end
      req_ready_o[w_grant] = w_push;
      rsp_valid_o[w_head]  = w_tagged;
      cu_ready_o   = w_cu_rdy;
      rsp_result_o = cu_result_i;
      rsp_status_o = cu_status_i;
      busy_o       = (r_count != '0) || (r_state == ST_HOLD);
      err_o        = r_err;
    end
  end

  // Arbitration FSM: HOLD keeps the grant on the port that saw backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_ARB;
      r_rr_ptr  <= '0;
      r_hold_id <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_drop;
      if (w_push) begin
        r_rr_ptr <= w_next_rr;
      end
      if (r_state == ST_ARB) begin
        if (w_cu_vld && !cu_ready_i) begin
          r_state   <= ST_HOLD;
          r_hold_id <= w_arb_id;
        end
      end else begin
        if (flush_i || cu_ready_i) begin
          r_state <= ST_ARB;
        end
      end
    end
  end

  // Tag FIFO of requester IDs, one entry per op inside the cast unit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < MAX_OUT; k++) begin
        r_tags[k] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_grant;
        r_wr_ptr         <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_posit_cast_sched.sv
module tb_posit_cast_sched;

  localparam int W = 32;
  localparam int N = 2;

  localparam logic [31:0] P0_OPND = 32'h4000_0000;
  localparam logic [1:0]  P0_OP   = 2'd2;
  localparam logic [2:0]  P0_RND  = 3'd1;
  localparam logic [31:0] P1_OPND = 32'h0000_0001;
  localparam logic [1:0]  P1_OP   = 2'd0;
  localparam logic [2:0]  P1_RND  = 3'd4;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_operand_i;
  logic [N*2-1:0] req_op_i;
  logic [N*3-1:0] req_rnd_i;
  logic           cu_valid_o;
  logic           cu_ready_i = 1'b0;
  logic [W-1:0]   cu_operand_o;
  logic [1:0]     cu_op_o;
  logic [2:0]     cu_rnd_o;
  logic           cu_flush_o;
  logic           cu_valid_i = 1'b0;
  logic           cu_ready_o;
  logic [W-1:0]   cu_result_i = '0;
  logic [4:0]     cu_status_i = '0;
  logic [N-1:0]   rsp_valid_o;
  logic [N-1:0]   rsp_ready_i = 2'b11;
  logic [W-1:0]   rsp_result_o;
  logic [4:0]     rsp_status_o;
  logic           busy_o;
  logic           err_o;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_g;
  logic [1:0] exp_r;

  always #5 clk_i = ~clk_i;

  posit_cast_sched #(.WIDTH(W), .NUM_REQ(N), .MAX_OUT(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operand_i(req_operand_i), .req_op_i(req_op_i), .req_rnd_i(req_rnd_i),
    .cu_valid_o(cu_valid_o), .cu_ready_i(cu_ready_i), .cu_operand_o(cu_operand_o),
    .cu_op_o(cu_op_o), .cu_rnd_o(cu_rnd_o), .cu_flush_o(cu_flush_o),
    .cu_valid_i(cu_valid_i), .cu_ready_o(cu_ready_o), .cu_result_i(cu_result_i),
    .cu_status_i(cu_status_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic [1:0] vld, input logic rdy, input logic rv,
                       input logic [31:0] res, input logic [4:0] st);
    req_valid_i = vld;
    cu_ready_i  = rdy;
    cu_valid_i  = rv;
    cu_result_i = res;
    cu_status_i = st;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    flush_i = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'h1F);
    settle();
    checks++;
    if ({req_ready_o, cu_valid_o, cu_operand_o, cu_op_o, cu_rnd_o, cu_flush_o, cu_ready_o,
         rsp_valid_o, rsp_result_o, rsp_status_o, busy_o, err_o} !== '0)
      begin errors++; $display("FAIL reset_outputs: got %h want 0", {req_ready_o, cu_valid_o,
        cu_operand_o, cu_op_o, cu_rnd_o, cu_flush_o, cu_ready_o, rsp_valid_o, rsp_result_o,
        rsp_status_o, busy_o, err_o}); end
    tick();
    rst_ni  = 1'b1;
    flush_i = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({busy_o, cu_valid_o, err_o, req_ready_o} !== 5'b0)
      begin errors++; $display("FAIL reset_release: got %b want 00000", {busy_o, cu_valid_o, err_o, req_ready_o}); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      tick();
      drive((k < 4) ? 2'b11 : 2'b00, 1'b1, (k >= 1), 32'h1000_0000 + k, 5'(k));
      settle();
      exp_g = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_r = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      checks++;
      if (req_ready_o !== exp_g)
        begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready_o, exp_g); end
      checks++;
      if (rsp_valid_o !== exp_r || (k >= 1 && rsp_result_o !== 32'h1000_0000 + k))
        begin errors++; $display("FAIL rr_rsp[%0d]: got %b/%h want %b", k, rsp_valid_o, rsp_result_o, exp_r); end
    end
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if (busy_o !== 1'b0)
      begin errors++; $display("FAIL rr_idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_hold();
    tick();
    drive(2'b10, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({cu_valid_o, req_ready_o, cu_op_o, cu_operand_o} !== {1'b1, 2'b00, P1_OP, P1_OPND})
      begin errors++; $display("FAIL hold_first: got %b %b %h %h", cu_valid_o, req_ready_o, cu_op_o, cu_operand_o); end
    for (int k = 0; k < 2; k++) begin
      tick();
      drive(2'b11, 1'b0, 1'b0, 32'h0, 5'h0);
      settle();
      checks++;
      if ({cu_valid_o, req_ready_o, cu_op_o, cu_operand_o, busy_o} !== {1'b1, 2'b00, P1_OP, P1_OPND, 1'b1})
        begin errors++; $display("FAIL hold_frozen[%0d]: got %b %b %h %h busy %b", k, cu_valid_o, req_ready_o, cu_op_o, cu_operand_o, busy_o); end
    end
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({cu_valid_o, req_ready_o, cu_op_o, cu_rnd_o} !== {1'b1, 2'b10, P1_OP, P1_RND})
      begin errors++; $display("FAIL hold_accept: got %b %b %h %h", cu_valid_o, req_ready_o, cu_op_o, cu_rnd_o); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h55, 5'h0);
    settle();
    checks++;
    if (rsp_valid_o !== 2'b10)
      begin errors++; $display("FAIL hold_rsp: got %b want 10", rsp_valid_o); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 2; k++) begin
      tick();
      drive(2'b01, 1'b1, 1'b0, 32'h0, 5'h0);
      settle();
      checks++;
      if (req_ready_o !== 2'b01)
        begin errors++; $display("FAIL full_fill[%0d]: got %b want 01", k, req_ready_o); end
    end
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({cu_valid_o, req_ready_o, busy_o} !== 4'b0001)
      begin errors++; $display("FAIL full_block: got %b want 0001", {cu_valid_o, req_ready_o, busy_o}); end
    tick();
    drive(2'b01, 1'b1, 1'b1, 32'hAB, 5'h0);
    settle();
    checks++;
    if ({cu_valid_o, req_ready_o, rsp_valid_o, cu_ready_o} !== 6'b000011)
      begin errors++; $display("FAIL full_pop_same_cycle: got %b want 000011", {cu_valid_o, req_ready_o, rsp_valid_o, cu_ready_o}); end
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({cu_valid_o, req_ready_o} !== 3'b101)
      begin errors++; $display("FAIL full_reissue: got %b want 101", {cu_valid_o, req_ready_o}); end
    tick();
    rsp_ready_i = 2'b10;
    drive(2'b00, 1'b0, 1'b1, 32'hC1, 5'h0);
    settle();
    checks++;
    if ({rsp_valid_o, cu_ready_o} !== 3'b010)
      begin errors++; $display("FAIL full_rsp_stall: got %b want 010", {rsp_valid_o, cu_ready_o}); end
    for (int k = 0; k < 2; k++) begin
      tick();
      rsp_ready_i = 2'b11;
      drive(2'b00, 1'b0, 1'b1, 32'hC2, 5'h0);
      settle();
      checks++;
      if ({rsp_valid_o, cu_ready_o} !== 3'b011)
        begin errors++; $display("FAIL full_drain[%0d]: got %b want 011", k, {rsp_valid_o, cu_ready_o}); end
    end
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if (busy_o !== 1'b0)
      begin errors++; $display("FAIL full_idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_order();
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({req_ready_o, cu_valid_o, cu_operand_o, cu_op_o, cu_rnd_o} !== {2'b01, 1'b1, P0_OPND, P0_OP, P0_RND})
      begin errors++; $display("FAIL order_issue0: got %b %b %h %h %h", req_ready_o, cu_valid_o, cu_operand_o, cu_op_o, cu_rnd_o); end
    tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({req_ready_o, cu_valid_o, cu_operand_o, cu_op_o, cu_rnd_o} !== {2'b10, 1'b1, P1_OPND, P1_OP, P1_RND})
      begin errors++; $display("FAIL order_issue1: got %b %b %h %h %h", req_ready_o, cu_valid_o, cu_operand_o, cu_op_o, cu_rnd_o); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0001, 5'b00001);
    settle();
    checks++;
    if ({rsp_valid_o, rsp_result_o, rsp_status_o} !== {2'b01, 32'h0000_0001, 5'b00001})
      begin errors++; $display("FAIL order_rsp0: got %b %h %b", rsp_valid_o, rsp_result_o, rsp_status_o); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h4000_0000, 5'b10100);
    settle();
    checks++;
    if ({rsp_valid_o, rsp_result_o, rsp_status_o} !== {2'b10, 32'h4000_0000, 5'b10100})
      begin errors++; $display("FAIL order_rsp1: got %b %h %b", rsp_valid_o, rsp_result_o, rsp_status_o); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      tick();
      drive(2'b01, 1'b1, 1'b0, 32'h0, 5'h0);
      settle();
      checks++;
      if (req_ready_o !== 2'b01)
        begin errors++; $display("FAIL flush_fill[%0d]: got %b want 01", k, req_ready_o); end
    end
    tick();
    flush_i = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'h77, 5'h3);
    settle();
    checks++;
    if ({cu_flush_o, cu_valid_o, req_ready_o, rsp_valid_o, busy_o} !== 7'b1000001)
      begin errors++; $display("FAIL flush_cycle: got %b want 1000001", {cu_flush_o, cu_valid_o, req_ready_o, rsp_valid_o, busy_o}); end
    tick();
    flush_i = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({busy_o, cu_flush_o} !== 2'b00)
      begin errors++; $display("FAIL flush_after: got %b want 00", {busy_o, cu_flush_o}); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h99, 5'h0);
    settle();
    checks++;
    if ({rsp_valid_o, cu_ready_o, err_o} !== 4'b0010)
      begin errors++; $display("FAIL stray_drop: got %b want 0010", {rsp_valid_o, cu_ready_o, err_o}); end
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if (err_o !== 1'b1)
      begin errors++; $display("FAIL stray_err_pulse: got %b want 1", err_o); end
    tick();
    settle();
    checks++;
    if (err_o !== 1'b0)
      begin errors++; $display("FAIL stray_err_clear: got %b want 0", err_o); end
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if (req_ready_o !== 2'b10)
      begin errors++; $display("FAIL flush_rr_kept: got %b want 10", req_ready_o); end
    tick();
    flush_i = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'h66, 5'h0);
    settle();
    checks++;
    if ({cu_flush_o, cu_valid_o, req_ready_o, rsp_valid_o} !== 6'b100000)
      begin errors++; $display("FAIL flush_blocks_issue: got %b want 100000", {cu_flush_o, cu_valid_o, req_ready_o, rsp_valid_o}); end
    tick();
    flush_i = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if (busy_o !== 1'b0)
      begin errors++; $display("FAIL flush2_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_reset_hold();
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if (req_ready_o !== 2'b01)
      begin errors++; $display("FAIL rh_issue: got %b want 01", req_ready_o); end
    tick();
    drive(2'b01, 1'b0, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({cu_valid_o, req_ready_o} !== 3'b100)
      begin errors++; $display("FAIL rh_stall: got %b want 100", {cu_valid_o, req_ready_o}); end
    tick();
    settle();
    checks++;
    if ({busy_o, cu_valid_o} !== 2'b11)
      begin errors++; $display("FAIL rh_in_hold: got %b want 11", {busy_o, cu_valid_o}); end
    #1;
    rst_ni = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 32'hCAFE, 5'h1F);
    #1;
    checks++;
    if ({req_ready_o, cu_valid_o, cu_operand_o, cu_op_o, cu_rnd_o, cu_flush_o, cu_ready_o,
         rsp_valid_o, rsp_result_o, rsp_status_o, busy_o, err_o} !== '0)
      begin errors++; $display("FAIL rh_reset_outputs: got %h want 0", {req_ready_o, cu_valid_o,
        cu_operand_o, cu_op_o, cu_rnd_o, cu_flush_o, cu_ready_o, rsp_valid_o, rsp_result_o,
        rsp_status_o, busy_o, err_o}); end
    tick();
    rst_ni = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 32'h0, 5'h0);
    settle();
    checks++;
    if ({busy_o, req_ready_o, cu_op_o} !== {1'b0, 2'b01, P0_OP})
      begin errors++; $display("FAIL rh_tie_port0: got %b %b %h", busy_o, req_ready_o, cu_op_o); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h5, 5'h0);
    settle();
    checks++;
    if (rsp_valid_o !== 2'b01)
      begin errors++; $display("FAIL rh_rsp: got %b want 01", rsp_valid_o); end
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 5'h0);
  endtask

  initial begin
    req_operand_i = {P1_OPND, P0_OPND};
    req_op_i      = {P1_OP, P0_OP};
    req_rnd_i     = {P1_RND, P0_RND};
    test_reset();
    test_round_robin();
    test_hold();
    test_full();
    test_order();
    test_flush();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
